// File: rtl/hazard_forward_unit.sv
// Data-hazard unit: shadow pipeline, EX operand forward selects, load-use stall.
// Optional stall-cycle counter built when HFU_PERF_CNT_EN is defined.
module hazard_forward_unit #(
  parameter int AW        = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int SW        = $clog2(FWD_DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [NUM_SRC*AW-1:0] id_rs,
  input  logic [AW-1:0]         id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic                  stall,
  output logic [NUM_SRC*SW-1:0] fwd_sel
`ifdef HFU_PERF_CNT_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  localparam int D = FWD_DEPTH + 1;

  logic [D:1]    vld_q;
  logic [D:1]    wr_q;
  logic [AW-1:0] rd_q [1:D];
  logic          ld_q;
  logic [AW-1:0] rs_q [NUM_SRC];
  logic          hit;
  logic          accept;

  assign accept = id_valid && !stall && !flush;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs[i*AW +: AW] == rd_q[1]) hit = 1'b1;
    end
    stall = id_valid && !flush && vld_q[1] && ld_q && wr_q[1]
            && (rd_q[1] != '0) && hit;
  end

  // Scan oldest to youngest so the nearest producer overwrites.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = D; k >= 2; k--) begin
        if (vld_q[k] && wr_q[k] && (rd_q[k] != '0)
            && (rd_q[k] == rs_q[i]))
          fwd_sel[i*SW +: SW] = SW'(k - 1);
      end
    end
    if (!vld_q[1]) fwd_sel = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      wr_q  <= '0;
      ld_q  <= 1'b0;
      for (int k = 1; k <= D; k++) rd_q[k] <= '0;
      for (int i = 0; i < NUM_SRC; i++) rs_q[i] <= '0;
    end else begin
      for (int k = 2; k <= D; k++) begin
        vld_q[k] <= vld_q[k-1];
        wr_q[k]  <= wr_q[k-1];
        rd_q[k]  <= rd_q[k-1];
      end
      vld_q[1] <= accept;
      wr_q[1]  <= accept && id_regwrite;
      ld_q     <= accept && id_memread;
      rd_q[1]  <= id_rd;
      for (int i = 0; i < NUM_SRC; i++) rs_q[i] <= id_rs[i*AW +: AW];
    end
  end

`ifdef HFU_PERF_CNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit (default parameters).
// Expected selects/stalls are hand-derived per test case.
module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int SW = 2;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [NS*AW-1:0] id_rs;
  logic [AW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_memread;
  logic          flush;
  logic          stall;
  logic [NS*SW-1:0] fwd_sel;
`ifdef HFU_PERF_CNT_EN
  logic [31:0]   stall_count;
`endif

  int n_chk;
  int n_fail;

  hazard_forward_unit #(
    .AW(AW), .NUM_SRC(NS), .FWD_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_rs(id_rs),
    .id_rd(id_rd),
    .id_regwrite(id_regwrite),
    .id_memread(id_memread),
    .flush(flush),
    .stall(stall),
    .fwd_sel(fwd_sel)
`ifdef HFU_PERF_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rd,
                       input logic wr, input logic ld,
                       input logic [AW-1:0] rs0,
                       input logic [AW-1:0] rs1, input logic fl);
    id_valid    = v;
    id_rd       = rd;
    id_regwrite = wr;
    id_memread  = ld;
    id_rs       = {rs1, rs0};
    flush       = fl;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      nop();
      tick();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    nop();
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fwd", {28'd0, fwd_sel}, 32'd0);
    #2 reset = 1'b0;
    tick();

    // add x5 ; add x6,x5,x1
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
    check("t1_stall_a", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd1, 1'b0);
    check("t1_stall_b", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("t1_fwd0", {30'd0, fwd_sel[1:0]}, 32'd1);
    check("t1_fwd1", {30'd0, fwd_sel[3:2]}, 32'd0);
    drain();

    // add x5 ; nop ; sub x7,x1,x5
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    nop();
    tick();
    drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd1, 5'd5, 1'b0);
    tick();
    nop();
    check("t2_fwd0", {30'd0, fwd_sel[1:0]}, 32'd0);
    check("t2_fwd1", {30'd0, fwd_sel[3:2]}, 32'd2);
    drain();

    // add x5 ; add x5 ; reader of x5 -> nearest
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd3, 5'd4, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0);
    tick();
    nop();
    check("t2_near", {30'd0, fwd_sel[1:0]}, 32'd1);
    drain();

    // lw x8 ; add x9,x8,x8
    drive(1'b1, 5'd8, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 5'd8, 1'b0);
    check("t3_stall1", {31'd0, stall}, 32'd1);
    tick();
    check("t3_stall2", {31'd0, stall}, 32'd0);
    check("t3_bubble", {28'd0, fwd_sel}, 32'd0);
    tick();
    nop();
    check("t3_fwd0", {30'd0, fwd_sel[1:0]}, 32'd2);
    check("t3_fwd1", {30'd0, fwd_sel[3:2]}, 32'd2);
    drain();

    // lw x8 ; lw x9,(x8) ; add rs x9
    drive(1'b1, 5'd8, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b1, 5'd8, 5'd0, 1'b0);
    check("b2b_s1", {31'd0, stall}, 32'd1);
    tick();
    check("b2b_s1b", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 5'd9, 1'b0);
    check("b2b_s2", {31'd0, stall}, 32'd1);
    tick();
    check("b2b_s2b", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("b2b_fwd", {30'd0, fwd_sel[3:2]}, 32'd2);
    drain();

    // lw x8 ; dependent with flush
    drive(1'b1, 5'd8, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 5'd8, 1'b1);
    check("t4_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("t4_fwd", {28'd0, fwd_sel}, 32'd0);
    drain();

    // x0 never matches
    drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    nop();
    check("t5_fwd_x0", {28'd0, fwd_sel}, 32'd0);
    drain();
    drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    check("t5_stall_x0", {31'd0, stall}, 32'd0);
    tick();
    drain();

    // producer ages past the last tracked slot
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    nop();
    tick();
    nop();
    tick();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 1'b0);
    tick();
    nop();
    check("age_out", {28'd0, fwd_sel}, 32'd0);
    drain();

`ifdef HFU_PERF_CNT_EN
    check("perf_cnt", stall_count, 32'd3);
`endif

    // three producers in flight, then async reset
    drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd11, 5'd12, 1'b0);
    tick();
    check("t6_pre0", {30'd0, fwd_sel[1:0]}, 32'd2);
    check("t6_pre1", {30'd0, fwd_sel[3:2]}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_fwd", {28'd0, fwd_sel}, 32'd0);
    check("t6_rst_stall", {31'd0, stall}, 32'd0);
`ifdef HFU_PERF_CNT_EN
    check("t6_rst_cnt", stall_count, 32'd0);
`endif
    tick();
    #2 reset = 1'b0;
    drive(1'b1, 5'd14, 1'b1, 1'b0, 5'd11, 5'd12, 1'b0);
    tick();
    nop();
    check("t6_post", {28'd0, fwd_sel}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
